// File: rtl/digit_entry_controller_pkg.sv
// Shared definitions for the digit entry path: FSM encoding, segment constants
// and the digit-to-segment lookup.
package digit_entry_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EDIT   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK       = 7'h7F;
  localparam logic [3:0] MAX_DIGIT_VALUE = 4'd9;

  // Active-low {g,f,e,d,c,b,a}; 0 and out-of-range codes show blank.
  function automatic logic [6:0] seg_encode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/digit_entry_controller_debouncer.sv
// Pushbutton conditioner: 2-flop synchroniser, stability counter, and a
// single-cycle pulse on an accepted press (release is accepted silently).
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_pulse
);
  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1, r_sync2, r_level, r_pulse;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;

  // Level flips once the synchronised input has disagreed for DEBOUNCE_CYCLES samples.
  assign w_accept = (r_sync2 != r_level) && (r_cnt == CNT_LAST);

  // Synchroniser, stability counter, accepted level and press pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_pulse <= w_accept && r_sync2;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_pulse = r_pulse;
endmodule

// File: rtl/digit_entry_controller.sv
// Digit entry controller: debounced buttons drive a cursor/value editor and
// hand committed (position,value) pairs to the puzzle logic via valid/ready.
module digit_entry_controller
  import digit_entry_controller_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int POS_W           = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btnNext,
  input  logic                  btnInc,
  input  logic                  btnCommit,
  input  logic                  commitReady,
  output logic [NUM_DIGITS-1:0] digitSel,
  output logic [6:0]            digitSeg,
  output logic                  commitValid,
  output logic [POS_W-1:0]      commitPos,
  output logic [3:0]            commitValue
);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_DIGITS - 1);

  logic [2:0] w_raw, w_pulse;
  assign w_raw = {btnCommit, btnNext, btnInc};

  for (genvar b = 0; b < 3; b++) begin : g_db
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .rst_n  (rst),
      .i_btn  (w_raw[b]),
      .o_pulse(w_pulse[b])
    );
  end

  // Same-cycle arbitration: commit beats next beats inc.
  logic w_commit, w_next, w_inc;
  assign w_commit = w_pulse[2];
  assign w_next   = w_pulse[1] & ~w_pulse[2];
  assign w_inc    = w_pulse[0] & ~w_pulse[1] & ~w_pulse[2];

  state_t                         r_state, w_state_nxt;
  logic [POS_W-1:0]               r_cursor, w_cursor_nxt;
  logic [NUM_DIGITS-1:0][3:0]     r_vals, w_vals_nxt;
  logic [POS_W-1:0]               r_cpos, w_cpos_nxt;
  logic [3:0]                     r_cval, w_cval_nxt;
  logic [3:0]                     w_cur_val;

  assign w_cur_val = r_vals[r_cursor];

  // State, cursor, value file and commit registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_cursor <= '0;
      r_vals   <= '0;
      r_cpos   <= '0;
      r_cval   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cursor <= w_cursor_nxt;
      r_vals   <= w_vals_nxt;
      r_cpos   <= w_cpos_nxt;
      r_cval   <= w_cval_nxt;
    end
  end

  // Next-state and datapath updates; the commit entry is frozen while in COMMIT.
  always_comb begin
    w_state_nxt  = r_state;
    w_cursor_nxt = r_cursor;
    w_vals_nxt   = r_vals;
    w_cpos_nxt   = r_cpos;
    w_cval_nxt   = r_cval;
    case (r_state)
      ST_IDLE: begin
        if (w_next) begin
          w_state_nxt  = ST_EDIT;
          w_cursor_nxt = '0;
        end
      end
      ST_EDIT: begin
        if (w_commit) begin
          w_state_nxt = ST_COMMIT;
          w_cpos_nxt  = r_cursor;
          w_cval_nxt  = w_cur_val;
        end else if (w_next) begin
          w_cursor_nxt = (r_cursor == POS_LAST) ? '0 : r_cursor + POS_W'(1);
        end else if (w_inc) begin
          w_vals_nxt[r_cursor] = (w_cur_val == MAX_DIGIT_VALUE) ? 4'd0 : w_cur_val + 4'd1;
        end
      end
      ST_COMMIT: begin
        if (commitReady) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from registered state.
  always_comb begin
    digitSel = '0;
    case (r_state)
      ST_EDIT:   digitSel = NUM_DIGITS'(1) << r_cursor;
      ST_COMMIT: digitSel = NUM_DIGITS'(1) << r_cpos;
      default:   digitSel = '0;
    endcase
  end

  assign digitSeg    = seg_encode(w_cur_val);
  assign commitValid = (r_state == ST_COMMIT);
  assign commitPos   = r_cpos;
  assign commitValue = r_cval;
endmodule

// File: tb/tb_digit_entry_controller.sv
// Directed bench for digit_entry_controller with a behavioural model feeding
// an expected-output scoreboard.
module tb_digit_entry_controller;
  localparam int ND = 4;
  localparam int DB = 4;
  localparam int PW = 2;

  logic clk = 1'b0, rst = 1'b0;
  logic bN = 1'b0, bI = 1'b0, bC = 1'b0, rdy = 1'b0;
  logic [ND-1:0] digitSel;
  logic [6:0]    digitSeg;
  logic          commitValid;
  logic [PW-1:0] commitPos;
  logic [3:0]    commitValue;

  digit_entry_controller #(.NUM_DIGITS(ND), .DEBOUNCE_CYCLES(DB), .POS_W(PW)) dut (
    .clk(clk), .rst(rst), .btnNext(bN), .btnInc(bI), .btnCommit(bC),
    .commitReady(rdy), .digitSel(digitSel), .digitSeg(digitSeg),
    .commitValid(commitValid), .commitPos(commitPos), .commitValue(commitValue)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [3:0] sel;
    logic [6:0] seg;
    logic       vld;
    logic [1:0] pos;
    logic [3:0] val;
  } exp_t;

  exp_t sb[$];
  int total = 0, bad = 0;

  logic [6:0] seg_tab [10] = '{7'h7F, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // Behavioural model
  int m_state, m_cur, m_cpos, m_cval;
  int m_vals [ND];

  // commitValid cycle monitor
  int vcnt = 0;
  logic [1:0] vpos = '0;
  logic [3:0] vval = '0;
  always @(negedge clk) if (commitValid === 1'b1) begin
    vcnt++;
    vpos = commitPos;
    vval = commitValue;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_cur = 0; m_cpos = 0; m_cval = 0;
    for (int k = 0; k < ND; k++) m_vals[k] = 0;
  endtask

  task automatic model_apply(input logic [2:0] m);
    logic c, n, i;
    c = m[2]; n = m[1] & ~m[2]; i = m[0] & ~m[1] & ~m[2];
    case (m_state)
      0: if (n) begin m_state = 1; m_cur = 0; end
      1: begin
        if (c) begin m_state = 2; m_cpos = m_cur; m_cval = m_vals[m_cur]; end
        else if (n) m_cur = (m_cur == ND - 1) ? 0 : m_cur + 1;
        else if (i) m_vals[m_cur] = (m_vals[m_cur] == 9) ? 0 : m_vals[m_cur] + 1;
      end
      default: ;
    endcase
    if (m_state == 2 && rdy) m_state = 0;
  endtask

  task automatic push_exp(input string tag);
    exp_t e;
    e.tag = tag;
    e.sel = (m_state == 1) ? 4'(1 << m_cur) : (m_state == 2) ? 4'(1 << m_cpos) : 4'd0;
    e.seg = seg_tab[m_vals[m_cur]];
    e.vld = (m_state == 2);
    e.pos = 2'(m_cpos);
    e.val = 4'(m_cval);
    sb.push_back(e);
  endtask

  task automatic check_sb();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, ".sel"}, 32'(digitSel), 32'(e.sel));
      chk({e.tag, ".seg"}, 32'(digitSeg), 32'(e.seg));
      chk({e.tag, ".vld"}, 32'(commitValid), 32'(e.vld));
      chk({e.tag, ".pos"}, 32'(commitPos), 32'(e.pos));
      chk({e.tag, ".val"}, 32'(commitValue), 32'(e.val));
    end
  endtask

  // Press a button set {commit,next,inc} long enough to be accepted, then release.
  task automatic press(input logic [2:0] m, input string tag);
    @(negedge clk); {bC, bN, bI} = m;
    repeat (12) @(negedge clk);
    {bC, bN, bI} = 3'b000;
    repeat (12) @(negedge clk);
    model_apply(m);
    push_exp(tag);
    check_sb();
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk); rst = 1'b0;
    #1;
    model_reset();
    push_exp(tag);
    check_sb();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  int v0;

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    push_exp("reset0");
    check_sb();
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Enter EDIT, then a bouncing inc yields exactly one increment.
    press(3'b010, "enter_edit");
    for (int k = 0; k < 6; k++) begin
      bI = ~bI;
      repeat (2) @(negedge clk);
    end
    press(3'b001, "bounce_inc");

    // Reset while editing clears outputs in the same cycle.
    do_reset("midrun_reset");

    // Value wrap 9 -> 0 and cursor wrap.
    press(3'b010, "edit2");
    for (int k = 0; k < 10; k++) press(3'b001, $sformatf("inc%0d", k + 1));
    for (int k = 0; k < 4; k++) press(3'b010, $sformatf("next%0d", k + 1));

    // Commit with back-pressure, ignored buttons, then release.
    press(3'b010, "cur1");
    press(3'b010, "cur2");
    for (int k = 0; k < 7; k++) press(3'b001, $sformatf("set7_%0d", k));
    press(3'b100, "commit");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      push_exp($sformatf("hold%0d", k));
      check_sb();
    end
    press(3'b001, "ign_inc");
    press(3'b010, "ign_next");
    rdy = 1'b1;
    @(negedge clk);
    m_state = 0;
    push_exp("ready_idle");
    check_sb();
    rdy = 1'b0;

    // Priority: simultaneous next+inc advances cursor, leaves value alone.
    press(3'b010, "edit3");
    for (int k = 0; k < 3; k++) press(3'b001, $sformatf("set3_%0d", k));
    press(3'b011, "prio");
    for (int k = 0; k < 3; k++) press(3'b010, $sformatf("back%0d", k));

    // Ready already high on COMMIT entry: exactly one valid cycle.
    rdy = 1'b1;
    v0 = vcnt;
    press(3'b100, "commit_rdy");
    chk("one_valid_cycle", 32'(vcnt - v0), 32'd1);
    chk("rdy_pos", 32'(vpos), 32'd0);
    chk("rdy_val", 32'(vval), 32'd3);
    rdy = 1'b0;

    // Reset during COMMIT aborts with no further valid cycles.
    press(3'b010, "edit4");
    press(3'b100, "commit2");
    do_reset("commit_reset");
    v0 = vcnt;
    repeat (20) @(negedge clk);
    chk("no_valid_after_reset", 32'(vcnt - v0), 32'd0);
    push_exp("post_reset");
    check_sb();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
